// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the ram read-port arbiter.
package ram_arb_pkg;

   // Upper bound on requesters; sizes the client index everywhere.
   localparam int NUM_RD_MAX   = 8;
   localparam int CLIENT_IDX_W = $clog2(NUM_RD_MAX);

   typedef logic [CLIENT_IDX_W-1:0] client_idx_t;

   // Encode a one-hot vector; an all-zero vector maps to index 0.
   function automatic client_idx_t onehot_to_idx(input logic [NUM_RD_MAX-1:0] oh);
      client_idx_t idx;
      idx = '0;
      for (int i = 0; i < NUM_RD_MAX; i++) begin
         if (oh[i]) idx = client_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates past the last winner.
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_RD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_RD-1:0] rd_valid,
   output logic [NUM_RD-1:0] grant
);

   client_idx_t           rr_ptr;
   logic                  found;
   logic [NUM_RD_MAX-1:0] grant_ext;

   // Search from rr_ptr+1 with wrap-around; first requesting client wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      if (enable) begin
         for (int k = 1; k <= NUM_RD; k++) begin
            for (int i = 0; i < NUM_RD; i++) begin
               if (!found && rd_valid[i] && (i == (int'(rr_ptr) + k) % NUM_RD)) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
         end
      end
   end

   // Widen the grant so the shared one-hot encoder can take it.
   always_comb begin
      grant_ext             = '0;
      grant_ext[NUM_RD-1:0] = grant;
   end

   // Remember the last winner; reset value makes client 0 first in line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rr_ptr <= client_idx_t'(NUM_RD - 1);
      else if (|grant)
         rr_ptr <= onehot_to_idx(grant_ext);
   end

endmodule

// File: rtl/ram_read_arbiter.sv
// Shares the ram read port among NUM_RD clients, passes the single writer
// straight through, and forwards write data on same-cycle address hits so
// every response carries the newest value one cycle after its grant.
module ram_read_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_RD         = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int RAM_OUTPUT_REG = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_enable,
   input  logic [NUM_RD-1:0]            rd_valid,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD-1:0]            rd_ready,
   output logic [NUM_RD-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]        rsp_data,
   input  logic                         wr_valid,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         ram_read_req,
   output logic [ADDR_WIDTH-1:0]        ram_read_addr,
   input  logic [DATA_WIDTH-1:0]        ram_read_data,
   output logic                         ram_write_req,
   output logic [ADDR_WIDTH-1:0]        ram_write_addr,
   output logic [DATA_WIDTH-1:0]        ram_write_data
);

   logic [NUM_RD-1:0]     grant;
   logic                  arb_en;
   logic                  collide;
   logic [NUM_RD-1:0]     rsp_tag;
   logic                  fwd_flag;
   logic [DATA_WIDTH-1:0] fwd_data;

   // No grants while reset is held, regardless of cfg_enable.
   assign arb_en = cfg_enable & reset;

   rr_arbiter #(
      .NUM_RD (NUM_RD)
   ) u_rr_arbiter (
      .clk      (clk),
      .reset    (reset),
      .enable   (arb_en),
      .rd_valid (rd_valid),
      .grant    (grant)
   );

   assign rd_ready     = grant;
   assign ram_read_req = |grant;

   // Address mux: AND-OR of the granted client's address, zero when idle.
   always_comb begin
      ram_read_addr = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (grant[i]) ram_read_addr = ram_read_addr | rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Writer goes straight to the ram; it is never stalled.
   assign ram_write_req  = wr_valid;
   assign ram_write_addr = wr_addr;
   assign ram_write_data = wr_data;

   // Same-cycle read/write to one address: ram would return the old word.
   assign collide = ram_read_req & wr_valid & (ram_read_addr == wr_addr);

   // Response tag: the grant vector delayed one cycle, exactly one pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rsp_tag <= '0;
      else
         rsp_tag <= grant;
   end

   assign rsp_valid = rsp_tag;

   // Forward state. With a combinational ram the flag only moves on a grant
   // so rsp_data holds between responses; with a registered ram it tracks
   // every cycle so idle rsp_data mirrors ram_read_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_flag <= 1'b0;
         fwd_data <= '0;
      end else begin
         if (ram_read_req || (RAM_OUTPUT_REG != 0))
            fwd_flag <= collide;
         if (collide)
            fwd_data <= wr_data;
      end
   end

   generate
      if (RAM_OUTPUT_REG == 0) begin : g_comb_ram
         logic [DATA_WIDTH-1:0] rd_data_q;

         // Capture the combinational ram word at the grant edge.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               rd_data_q <= '0;
            else if (ram_read_req)
               rd_data_q <= ram_read_data;
         end

         assign rsp_data = fwd_flag ? fwd_data : rd_data_q;
      end else begin : g_reg_ram
         // The ram already registered the word; only the forward mux is ours.
         assign rsp_data = !reset ? '0 : (fwd_flag ? fwd_data : ram_read_data);
      end
   endgenerate

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed bench: two arbiters (combinational and registered ram) run the
// same stimulus against small ram models and must produce identical traces.
module tb_ram_read_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int AW = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_enable;
   logic [NR-1:0]     rd_valid;
   logic [NR*AW-1:0]  rd_addr;
   logic              wr_valid;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;

   logic [1:0][NR-1:0] rd_ready_w;
   logic [1:0][NR-1:0] rsp_valid_w;
   logic [1:0][DW-1:0] rsp_data_w;
   logic [1:0]         ram_rreq_w;
   logic [1:0][AW-1:0] ram_raddr_w;
   logic [1:0]         ram_wreq_w;
   logic [1:0][AW-1:0] ram_waddr_w;
   logic [1:0][DW-1:0] ram_wdata_w;
   logic [DW-1:0]      rdata0;
   logic [DW-1:0]      rdata1;

   logic [DW-1:0] mem0 [0:(1<<AW)-1];
   logic [DW-1:0] mem1 [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return 32'h5A00_0000 | {20'h0, a};
   endfunction

   // Ram with combinational read.
   assign rdata0 = mem0[ram_raddr_w[0]];
   always @(posedge clk) begin
      if (ram_wreq_w[0]) mem0[ram_waddr_w[0]] <= ram_wdata_w[0];
   end

   // Ram with registered read (read-before-write).
   always @(posedge clk) begin
      if (ram_rreq_w[1]) rdata1 <= mem1[ram_raddr_w[1]];
      if (ram_wreq_w[1]) mem1[ram_waddr_w[1]] <= ram_wdata_w[1];
   end

   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         mem0[a] = pat(AW'(a));
         mem1[a] = pat(AW'(a));
      end
      mem0[12'h010] = 32'hA5A5_0001; mem1[12'h010] = 32'hA5A5_0001;
      mem0[12'h020] = 32'h0000_0001; mem1[12'h020] = 32'h0000_0001;
      rdata1 = '0;
   end

   ram_read_arbiter #(.NUM_RD(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_OUTPUT_REG(0)) u_dut0 (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready_w[0]),
      .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .ram_read_req(ram_rreq_w[0]), .ram_read_addr(ram_raddr_w[0]), .ram_read_data(rdata0),
      .ram_write_req(ram_wreq_w[0]), .ram_write_addr(ram_waddr_w[0]), .ram_write_data(ram_wdata_w[0])
   );

   ram_read_arbiter #(.NUM_RD(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_OUTPUT_REG(1)) u_dut1 (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready_w[1]),
      .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .ram_read_req(ram_rreq_w[1]), .ram_read_addr(ram_raddr_w[1]), .ram_read_data(rdata1),
      .ram_write_req(ram_wreq_w[1]), .ram_write_addr(ram_waddr_w[1]), .ram_write_data(ram_wdata_w[1])
   );

   task automatic set_addr(input int c, input logic [AW-1:0] a);
      rd_addr[c*AW +: AW] = a;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0000 || ram_rreq_w[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready dut%0d got rdy=%b req=%b exp 0000/0", d, rd_ready_w[d], ram_rreq_w[d]);
         end
         checks++;
         if (rsp_valid_w[d] !== 4'b0000 || rsp_data_w[d] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp dut%0d got v=%b d=%h exp 0000/0", d, rsp_valid_w[d], rsp_data_w[d]);
         end
      end
      @(posedge clk);
      #1;
      reset    = 1'b1;
      rd_valid = '0;
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] e;
      logic [NR-1:0] ev;
      for (int c = 0; c < NR; c++) set_addr(c, AW'(12'h100 + c));
      rd_valid = 4'hF;
      for (int k = 0; k < 9; k++) begin
         if (k == 8) rd_valid = '0;
         #1;
         e = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_ready_w[d] !== e || ram_rreq_w[d] !== (k < 8)) begin
               errors++;
               $display("FAIL rr_grant dut%0d k=%0d got %b exp %b", d, k, rd_ready_w[d], e);
            end
            if (k > 0) begin
               ev = 4'b0001 << ((k - 1) % 4);
               checks++;
               if (rsp_valid_w[d] !== ev || rsp_data_w[d] !== pat(AW'(12'h100 + (k - 1) % 4))) begin
                  errors++;
                  $display("FAIL rr_rsp dut%0d k=%0d got %b/%h exp %b/%h", d, k, rsp_valid_w[d],
                           rsp_data_w[d], ev, pat(AW'(12'h100 + (k - 1) % 4)));
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_single();
      set_addr(2, 12'h010);
      rd_valid = 4'b0100;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0100 || ram_raddr_w[d] !== 12'h010) begin
            errors++;
            $display("FAIL single_grant dut%0d got %b@%h exp 0100@010", d, rd_ready_w[d], ram_raddr_w[d]);
         end
      end
      next_cycle();
      rd_valid = '0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b0100 || rsp_data_w[d] !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL single_rsp dut%0d got %b/%h exp 0100/a5a50001", d, rsp_valid_w[d], rsp_data_w[d]);
         end
      end
      next_cycle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b0000) begin
            errors++;
            $display("FAIL single_pulse dut%0d got %b exp 0000", d, rsp_valid_w[d]);
         end
      end
   endtask

   task automatic test_collision();
      set_addr(1, 12'h020);
      rd_valid = 4'b0010;
      wr_valid = 1'b1;
      wr_addr  = 12'h020;
      wr_data  = 32'hDEAD_BEEF;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0010 || ram_wreq_w[d] !== 1'b1 ||
             ram_waddr_w[d] !== 12'h020 || ram_wdata_w[d] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL coll_pass dut%0d got %b %b %h %h exp 0010 1 020 deadbeef", d,
                     rd_ready_w[d], ram_wreq_w[d], ram_waddr_w[d], ram_wdata_w[d]);
         end
      end
      next_cycle();
      wr_valid = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b0010 || rsp_data_w[d] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL coll_fwd dut%0d got %b/%h exp 0010/deadbeef", d, rsp_valid_w[d], rsp_data_w[d]);
         end
      end
      next_cycle();
      rd_valid = '0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b0010 || rsp_data_w[d] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL coll_reread dut%0d got %b/%h exp 0010/deadbeef", d, rsp_valid_w[d], rsp_data_w[d]);
         end
      end
      next_cycle();
   endtask

   task automatic test_disable();
      set_addr(0, 12'h010);
      set_addr(3, 12'h040);
      rd_valid = 4'b0001;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0001) begin
            errors++;
            $display("FAIL dis_pre dut%0d got %b exp 0001", d, rd_ready_w[d]);
         end
      end
      next_cycle();
      cfg_enable = 1'b0;
      rd_valid   = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         wr_valid = (k == 1);
         wr_addr  = 12'h040;
         wr_data  = 32'h1234_5678;
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_ready_w[d] !== 4'b0000 || ram_rreq_w[d] !== 1'b0) begin
               errors++;
               $display("FAIL dis_ready dut%0d k=%0d got %b/%b exp 0000/0", d, k, rd_ready_w[d], ram_rreq_w[d]);
            end
            if (k == 0) begin
               checks++;
               if (rsp_valid_w[d] !== 4'b0001 || rsp_data_w[d] !== 32'hA5A5_0001) begin
                  errors++;
                  $display("FAIL dis_pending dut%0d got %b/%h exp 0001/a5a50001", d, rsp_valid_w[d], rsp_data_w[d]);
               end
            end else begin
               checks++;
               if (rsp_valid_w[d] !== 4'b0000) begin
                  errors++;
                  $display("FAIL dis_rsp dut%0d k=%0d got %b exp 0000", d, k, rsp_valid_w[d]);
               end
            end
         end
         next_cycle();
      end
      wr_valid   = 1'b0;
      cfg_enable = 1'b1;
      rd_valid   = 4'b1000;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b1000) begin
            errors++;
            $display("FAIL dis_reen dut%0d got %b exp 1000", d, rd_ready_w[d]);
         end
      end
      next_cycle();
      rd_valid = '0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b1000 || rsp_data_w[d] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dis_readback dut%0d got %b/%h exp 1000/12345678", d, rsp_valid_w[d], rsp_data_w[d]);
         end
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      set_addr(1, 12'h030);
      rd_valid = 4'b0010;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0010) begin
            errors++;
            $display("FAIL rst_pre dut%0d got %b exp 0010", d, rd_ready_w[d]);
         end
      end
      #2;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0000 || ram_rreq_w[d] !== 1'b0) begin
            errors++;
            $display("FAIL rst_gate dut%0d got %b/%b exp 0000/0", d, rd_ready_w[d], ram_rreq_w[d]);
         end
      end
      next_cycle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b0000 || rsp_data_w[d] !== 32'h0) begin
            errors++;
            $display("FAIL rst_drop dut%0d got %b/%h exp 0000/0", d, rsp_valid_w[d], rsp_data_w[d]);
         end
      end
      reset = 1'b1;
      set_addr(0, 12'h100);
      set_addr(3, 12'h130);
      rd_valid = 4'b1001;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_ready_w[d] !== 4'b0001) begin
            errors++;
            $display("FAIL rst_tie dut%0d got %b exp 0001", d, rd_ready_w[d]);
         end
      end
      next_cycle();
      rd_valid = '0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rsp_valid_w[d] !== 4'b0001 || rsp_data_w[d] !== pat(12'h100)) begin
            errors++;
            $display("FAIL rst_after dut%0d got %b/%h exp 0001/%h", d, rsp_valid_w[d], rsp_data_w[d], pat(12'h100));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b0;
      cfg_enable = 1'b1;
      rd_valid   = 4'hF;
      rd_addr    = '0;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_collision();
      test_disable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
